zbb_bitcount_unit: RTL and testbench

//   Pipelined Zbb bit-count execution unit: CLZ, CTZ, CPOP and their RV64 word forms.

---
 rtl/zbb_pkg.sv | 21 ++
 rtl/zbb_lzc_tree.sv | 41 ++++
 rtl/zbb_bitcount_unit.sv | 126 ++++++++++++
 tb/tb_zbb_bitcount_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbb_pkg.sv
// Shared types and helpers for the Zbb bit-count execution unit.
// No logic, no latency.
// No flow control.
package zbb_pkg;

  typedef enum logic [1:0] {
    BC_CLZ  = 2'b00,
    BC_CTZ  = 2'b01,
    BC_CPOP = 2'b10,
    BC_RSVD = 2'b11
  } bitcnt_op_e;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  // Width needed to hold a count of 0..xlen inclusive.
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/zbb_lzc_tree.sv
// Recursive leading-zero counter for a power-of-two WIDTH; count valid only when !all_zero.
// Combinational, zero latency.
// No flow control.
module zbb_lzc_tree #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data,
  output logic                     all_zero,
  output logic [$clog2(WIDTH)-1:0] count
);

  if (WIDTH == 2) begin : g_leaf
    assign all_zero = ~(data[1] | data[0]);
    assign count    = ~data[1];
  end else begin : g_node
    localparam int HW  = WIDTH / 2;
    localparam int HCW = $clog2(HW);

    logic           hi_zero;
    logic           lo_zero;
    logic [HCW-1:0] hi_cnt;
    logic [HCW-1:0] lo_cnt;

    zbb_lzc_tree #(.WIDTH(HW)) u_hi (
      .data     (data[WIDTH-1:HW]),
      .all_zero (hi_zero),
      .count    (hi_cnt)
    );

    zbb_lzc_tree #(.WIDTH(HW)) u_lo (
      .data     (data[HW-1:0]),
      .all_zero (lo_zero),
      .count    (lo_cnt)
    );

    // An empty upper half contributes HW zeros, so the MSB of the count is hi_zero.
    assign all_zero = hi_zero & lo_zero;
    assign count    = hi_zero ? {1'b1, lo_cnt} : {1'b0, hi_cnt};
  end

endmodule

// File: rtl/zbb_bitcount_unit.sv
// Zbb CLZ/CTZ/CPOP (and RV64 word forms) execute unit with pass-through tag.
// Latency STAGES cycles (1 or 2) from accept to out_valid; one op per cycle, in order.
// Whole pipe advances together when the output is empty or drained; in_ready = advance.
module zbb_bitcount_unit
  import zbb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_operand,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = cnt_w(XLEN);
  localparam int LW = $clog2(XLEN);

  // Word mode left-aligns the 32-bit window in the tree; ones below it cap the count at 32.
  localparam logic [XLEN-1:0] PAD_ONES  = {XLEN{1'b1}} >> 32;
  localparam logic [XLEN-1:0] WORD_MASK = {XLEN{1'b1}} >> (XLEN - 32);

  typedef struct packed {
    logic             vld;
    bitcnt_op_e       op;
    logic [XLEN-1:0]  lzc_src;
    logic [XLEN-1:0]  pop_src;
    logic [TAG_W-1:0] tag;
  } prep_t;

  logic            advance;
  logic            word_mode;
  logic [XLEN-1:0] op_rev;
  prep_t           prep_a;
  prep_t           prep_b;
  logic            lzc_zero;
  logic [LW-1:0]   lzc_cnt;
  logic [CW-1:0]   pop_cnt;
  logic [CW-1:0]   result;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign word_mode = (XLEN == XLEN_64) && in_word;

  // Full-width bit reversal; in word mode the reversed low word lands in the top 32 bits.
  always_comb begin
    op_rev = '0;
    for (int i = 0; i < XLEN; i++) begin
      op_rev[XLEN-1-i] = in_operand[i];
    end
  end

  // Stage A: shape the operand so a single leading-zero tree serves CLZ and CTZ.
  always_comb begin
    prep_a         = '0;
    prep_a.vld     = in_valid;
    prep_a.op      = bitcnt_op_e'(in_op);
    prep_a.tag     = in_tag;
    prep_a.pop_src = word_mode ? (in_operand & WORD_MASK) : in_operand;
    if (word_mode) begin
      prep_a.lzc_src = ((prep_a.op == BC_CTZ) ? op_rev : (in_operand << (XLEN - 32))) | PAD_ONES;
    end else begin
      prep_a.lzc_src = (prep_a.op == BC_CTZ) ? op_rev : in_operand;
    end
  end

  if (STAGES == 2) begin : g_prep_reg
    // Optional register between operand prep and count; shifts with the rest of the pipe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prep_b <= '0;
      end else if (advance) begin
        prep_b <= prep_a;
      end
    end
  end else begin : g_prep_comb
    assign prep_b = prep_a;
  end

  zbb_lzc_tree #(.WIDTH(XLEN)) u_lzc (
    .data     (prep_b.lzc_src),
    .all_zero (lzc_zero),
    .count    (lzc_cnt)
  );

  // Population count as an adder reduction over the masked window.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < XLEN; i++) begin
      pop_cnt = pop_cnt + CW'(prep_b.pop_src[i]);
    end
  end

  // Op select; an all-zero tree input only occurs for a full-width window.
  always_comb begin
    result = '0;
    case (prep_b.op)
      BC_CLZ, BC_CTZ: result = lzc_zero ? CW'(XLEN) : CW'(lzc_cnt);
      BC_CPOP:        result = pop_cnt;
      default:        result = '0;
    endcase
  end

  // Output register: loads on advance (bubbles clear it), holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (advance) begin
      out_valid  <= prep_b.vld;
      out_result <= prep_b.vld ? XLEN'(result) : '0;
      out_tag    <= prep_b.vld ? prep_b.tag : '0;
    end
  end

endmodule

// File: tb/tb_zbb_bitcount_unit.sv
// Scoreboard bench for zbb_bitcount_unit: index 0 is XLEN=32/STAGES=1, index 1 is XLEN=64/STAGES=2.
// Drivers push expected results into per-DUT queues; a negedge monitor pops on each output handshake.
// Directed spec cases, backpressure, reset mid-flight and a 1000-op random burst per DUT.
module tb_zbb_bitcount_unit;
  import zbb_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv    [2];
  logic [1:0]  iop   [2];
  logic        iw    [2];
  logic [63:0] iopnd [2];
  logic [4:0]  itag  [2];
  logic        ordy  [2];

  logic        ir0, ir1, ov0, ov1;
  logic [4:0]  otag0, otag1;
  logic [31:0] ores32;
  logic [63:0] ores64;

  logic        ir   [2];
  logic        ov   [2];
  logic [4:0]  otag [2];
  logic [63:0] ores [2];

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  bit   burst [2];
  bit   seen  [2];
  int   bub   [2];
  int   waits [2];

  always #5 clk = ~clk;

  always_comb begin
    ir[0] = ir0;   ir[1] = ir1;
    ov[0] = ov0;   ov[1] = ov1;
    otag[0] = otag0; otag[1] = otag1;
    ores[0] = {32'b0, ores32};
    ores[1] = ores64;
  end

  zbb_bitcount_unit #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir0), .in_op(iop[0]), .in_word(iw[0]),
    .in_operand(iopnd[0][31:0]), .in_tag(itag[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_result(ores32), .out_tag(otag0)
  );

  zbb_bitcount_unit #(.XLEN(64), .STAGES(2), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir1), .in_op(iop[1]), .in_word(iw[1]),
    .in_operand(iopnd[1]), .in_tag(itag[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_result(ores64), .out_tag(otag1)
  );

  // Reference: scan the window bit by bit; word forms use a 32-bit window on RV64.
  function automatic logic [63:0] model(input int xlen, input logic [1:0] op,
                                        input logic word, input logic [63:0] v);
    int          w;
    int          n;
    bit          found;
    logic [63:0] m;
    w     = (xlen == 64 && word) ? 32 : xlen;
    m     = (w == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
    n     = 0;
    found = 0;
    case (op)
      2'b00: for (int i = w - 1; i >= 0; i--) begin
               if (!found) begin if (m[i]) found = 1; else n++; end
             end
      2'b01: for (int i = 0; i < w; i++) begin
               if (!found) begin if (m[i]) found = 1; else n++; end
             end
      2'b10: n = $countones(m);
      default: n = 0;
    endcase
    return 64'(n);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Present one op, wait (bounded) for in_ready, record the expectation, complete the transfer.
  task automatic send_exp(input int d, input logic [1:0] op, input logic w,
                          input logic [63:0] v, input logic [4:0] tag, input logic [63:0] res);
    bit   ok;
    exp_t e;
    iv[d] = 1'b1; iop[d] = op; iw[d] = w; iopnd[d] = v; itag[d] = tag;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (ir[d]) ok = 1;
      else       waits[d]++;
    end
    if (ok) begin
      e.res = res; e.tag = tag;
      push(d, e);
      @(posedge clk); #1;
    end else begin
      tests++; fails++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1 within 100 cycles", d);
    end
    iv[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [1:0] op, input logic w,
                      input logic [63:0] v, input logic [4:0] tag);
    send_exp(d, op, w, v, tag, model(d == 0 ? 32 : 64, op, w, v));
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout dut%0d: %0d results outstanding, required 0", d, qsize(d));
    end
    @(posedge clk); #1;
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (burst[d]) begin
      if (ov[d])                        seen[d] = 1;
      else if (seen[d] && qsize(d) > 0) bub[d]++;
    end
    if (ov[d] && ordy[d]) begin
      tests++;
      if (qsize(d) == 0) begin
        fails++;
        $display("FAIL unexpected_output dut%0d: got result %0h tag %0d, required no output",
                 d, ores[d], otag[d]);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (ores[d] !== e.res || otag[d] !== e.tag) begin
          fails++;
          $display("FAIL result dut%0d: got result %0h tag %0d, required result %0h tag %0d",
                   d, ores[d], otag[d], e.res, e.tag);
        end
      end
    end
  endtask

  // Monitor: outputs and out_ready are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  task automatic backpressure(input int d);
    logic [63:0] hres;
    logic [4:0]  htag;
    int          n;
    ordy[d] = 1'b0;
    fork
      begin
        send(d, BC_CPOP, 1'b0, 64'h0000_0000_0000_00FF, 5'd1);
        send(d, BC_CLZ,  1'b0, 64'h0000_0000_0000_1000, 5'd2);
        send(d, BC_CTZ,  1'b0, 64'h0000_0000_0004_0000, 5'd3);
      end
      begin
        n = 0;
        while (!ov[d] && n < 20) begin @(negedge clk); n++; end
        chk("bp_first_valid", ov[d], 1'b1);
        hres = ores[d];
        htag = otag[d];
        repeat (5) begin
          @(negedge clk);
          chk("bp_held_valid", ov[d], 1'b1);
          chk("bp_held_result", ores[d], hres);
          chk("bp_held_tag", otag[d], htag);
          chk("bp_in_ready_low", ir[d], 1'b0);
        end
        @(posedge clk); #1;
        ordy[d] = 1'b1;
      end
    join
    wait_drain(d);
  endtask

  task automatic random_burst(input int d);
    logic [1:0]  op;
    logic        w;
    logic [63:0] v;
    logic [63:0] one;
    logic [63:0] ones;
    one  = 64'h1;
    ones = ~64'h0;
    burst[d] = 1; seen[d] = 0; bub[d] = 0; waits[d] = 0;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       v = '0;
        1:       v = one << $urandom_range(0, 63);
        2:       v = ones >> $urandom_range(0, 63);
        default: v = {$urandom, $urandom};
      endcase
      send(d, op, w, v, 5'(i));
    end
    wait_drain(d);
    burst[d] = 0;
    chk("burst_bubbles", 64'(bub[d]), 64'd0);
    chk("burst_input_stalls", 64'(waits[d]), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; iop[d] = 0; iw[d] = 0; iopnd[d] = 0; itag[d] = 0; ordy[d] = 1;
      burst[d] = 0; seen[d] = 0; bub[d] = 0; waits[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_out_valid", ov[d], 1'b0);
      chk("reset_out_result", ores[d], 64'd0);
      chk("reset_out_tag", otag[d], 5'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready32", ir[0], 1'b1);
    chk("reset_in_ready64", ir[1], 1'b1);

    // XLEN=32, STAGES=1
    send_exp(0, BC_CLZ, 1'b0, 64'h0000_0001, 5'd1, 64'd31);
    chk("latency1_valid", ov[0], 1'b1);
    send_exp(0, BC_CLZ,  1'b0, 64'h8000_0000, 5'd2, 64'd0);
    send_exp(0, BC_CLZ,  1'b0, 64'h0000_0000, 5'd3, 64'd32);
    send_exp(0, BC_CTZ,  1'b0, 64'h0000_0100, 5'd4, 64'd8);
    send_exp(0, BC_CTZ,  1'b0, 64'h0000_0000, 5'd5, 64'd32);
    send_exp(0, BC_CPOP, 1'b0, 64'hA5A5_A5A5, 5'd6, 64'd16);
    send_exp(0, BC_CPOP, 1'b0, 64'hFFFF_FFFF, 5'd7, 64'd32);
    send_exp(0, BC_RSVD, 1'b0, 64'hFFFF_FFFF, 5'd8, 64'd0);
    send_exp(0, BC_CLZ,  1'b1, 64'h0000_0001, 5'd9, 64'd31);
    wait_drain(0);

    // XLEN=64, STAGES=2
    send_exp(1, BC_CLZ, 1'b1, 64'hFFFF_FFFF_0000_8000, 5'd1, 64'd16);
    chk("latency2_not_early", ov[1], 1'b0);
    @(posedge clk); #1;
    chk("latency2_valid", ov[1], 1'b1);
    send_exp(1, BC_CTZ,  1'b1, 64'hFFFF_0000_0000_0000, 5'd2, 64'd32);
    send_exp(1, BC_CPOP, 1'b1, 64'hFFFF_FFFF_0000_000F, 5'd3, 64'd4);
    send_exp(1, BC_CLZ,  1'b0, 64'h0,                   5'd4, 64'd64);
    send_exp(1, BC_CTZ,  1'b0, 64'h0,                   5'd5, 64'd64);
    send_exp(1, BC_CLZ,  1'b1, 64'h0,                   5'd6, 64'd32);
    send_exp(1, BC_CTZ,  1'b0, 64'h8000_0000_0000_0000, 5'd7, 64'd63);
    send_exp(1, BC_CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd64);
    send_exp(1, BC_RSVD, 1'b1, 64'h1234_5678_9ABC_DEF0, 5'd9, 64'd0);
    wait_drain(1);

    backpressure(0);
    backpressure(1);

    // Reset with two ops in flight in the two-stage unit.
    send(1, BC_CPOP, 1'b0, 64'h0F0F, 5'd20);
    send(1, BC_CLZ,  1'b0, 64'h0100, 5'd21);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", ov[1], 1'b0);
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_stale_valid", ov[1], 1'b0);
      chk("rst_in_ready", ir[1], 1'b1);
    end
    @(posedge clk); #1;

    random_burst(0);
    random_burst(1);

    chk("q32_empty", 64'(q0.size()), 64'd0);
    chk("q64_empty", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
